// File: rtl/operand_fetch_if.sv
// Bundle of instruction-in, regfile, writeback and execute-out signals for operand_fetch.
// The slave modport is the operand_fetch view. The master modport is the surrounding pipeline view.
interface operand_fetch_if #(
    parameter int PAYLOAD_W = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [4:0]           in_rs_a;
    logic [4:0]           in_rs_b;
    logic [4:0]           in_rd;
    logic                 in_rd_we;
    logic [PAYLOAD_W-1:0] in_payload;

    logic [4:0]           ctrl_readRegA;
    logic [4:0]           ctrl_readRegB;
    logic [31:0]          data_readRegA;
    logic [31:0]          data_readRegB;

    logic                 wb_valid;
    logic [4:0]           wb_rd;
    logic [31:0]          wb_data;

    logic                 ctrl_writeEnable;
    logic [4:0]           ctrl_writeReg;
    logic [31:0]          data_writeReg;

    logic                 out_valid;
    logic                 out_ready;
    logic [31:0]          out_op_a;
    logic [31:0]          out_op_b;
    logic [4:0]           out_rd;
    logic                 out_rd_we;
    logic [PAYLOAD_W-1:0] out_payload;

    modport slave (
        input  in_valid, in_rs_a, in_rs_b, in_rd, in_rd_we, in_payload,
        output in_ready,
        output ctrl_readRegA, ctrl_readRegB,
        input  data_readRegA, data_readRegB,
        input  wb_valid, wb_rd, wb_data,
        output ctrl_writeEnable, ctrl_writeReg, data_writeReg,
        output out_valid, out_op_a, out_op_b, out_rd, out_rd_we, out_payload,
        input  out_ready
    );

    modport master (
        output in_valid, in_rs_a, in_rs_b, in_rd, in_rd_we, in_payload,
        input  in_ready,
        input  ctrl_readRegA, ctrl_readRegB,
        output data_readRegA, data_readRegB,
        output wb_valid, wb_rd, wb_data,
        input  ctrl_writeEnable, ctrl_writeReg, data_writeReg,
        input  out_valid, out_op_a, out_op_b, out_rd, out_rd_we, out_payload,
        output out_ready
    );
endinterface

// File: rtl/operand_fetch.sv
// Operand fetch stage: reads the register file, tracks pending writes per register,
// stalls on RAW hazards, bypasses writeback data and issues through a registered output stage.
module operand_fetch #(
    parameter int PAYLOAD_W = 32,
    parameter int CNT_W     = 2
) (
    input  logic           clock,
    input  logic           ctrl_reset,
    operand_fetch_if.slave bus
);
    localparam logic [CNT_W-1:0] PEND_MAX = '1;

    logic [CNT_W-1:0]     pend [32];
    logic [31:0]          inc_vec;
    logic [31:0]          dec_vec;

    logic                 ok_a, ok_b;
    logic [31:0]          op_a, op_b;
    logic                 rd_full;
    logic                 hazard;
    logic                 ready;
    logic                 accept;

    logic                 out_valid_q;
    logic [31:0]          op_a_q, op_b_q;
    logic [4:0]           rd_q;
    logic                 rd_we_q;
    logic [PAYLOAD_W-1:0] payload_q;

    // Returns {resolved, operand}. A single pending write may be satisfied by this cycle's writeback.
    function automatic logic [32:0] resolve(
        input logic [4:0]       rs,
        input logic [CNT_W-1:0] cnt,
        input logic [31:0]      rf_data,
        input logic             wb_v,
        input logic [4:0]       wb_r,
        input logic [31:0]      wb_d
    );
        logic [32:0] res;
        res = '0;
        if (rs == 5'd0) begin
            res = {1'b1, 32'd0};
        end else if (cnt == '0) begin
            res = {1'b1, rf_data};
        end else if (cnt == CNT_W'(1) && wb_v && wb_r == rs) begin
            res = {1'b1, wb_d};
        end
        return res;
    endfunction

    assign bus.ctrl_readRegA    = bus.in_rs_a;
    assign bus.ctrl_readRegB    = bus.in_rs_b;
    assign bus.ctrl_writeEnable = bus.wb_valid & (bus.wb_rd != 5'd0);
    assign bus.ctrl_writeReg    = bus.wb_rd;
    assign bus.data_writeReg    = bus.wb_data;

    always_comb begin
        {ok_a, op_a} = resolve(bus.in_rs_a, pend[bus.in_rs_a], bus.data_readRegA,
                               bus.wb_valid, bus.wb_rd, bus.wb_data);
        {ok_b, op_b} = resolve(bus.in_rs_b, pend[bus.in_rs_b], bus.data_readRegB,
                               bus.wb_valid, bus.wb_rd, bus.wb_data);
    end

    assign rd_full = bus.in_rd_we && (bus.in_rd != 5'd0) && (pend[bus.in_rd] == PEND_MAX);
    assign hazard  = !ok_a || !ok_b || rd_full;
    assign ready   = ctrl_reset && (!out_valid_q || bus.out_ready) && !hazard;
    assign accept  = bus.in_valid && ready;

    assign bus.in_ready = ready;

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        if (accept && bus.in_rd_we && bus.in_rd != 5'd0) begin
            inc_vec[bus.in_rd] = 1'b1;
        end
        // Writeback with nothing pending still reaches the regfile but must not underflow.
        if (bus.wb_valid && bus.wb_rd != 5'd0 && pend[bus.wb_rd] != '0) begin
            dec_vec[bus.wb_rd] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!ctrl_reset) begin
            for (int r = 0; r < 32; r++) begin
                pend[r] <= '0;
            end
        end else begin
            pend[0] <= '0;
            for (int r = 1; r < 32; r++) begin
                if (inc_vec[r] && !dec_vec[r]) begin
                    pend[r] <= pend[r] + CNT_W'(1);
                end else if (dec_vec[r] && !inc_vec[r]) begin
                    pend[r] <= pend[r] - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!ctrl_reset) begin
            out_valid_q <= 1'b0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            rd_q        <= '0;
            rd_we_q     <= 1'b0;
            payload_q   <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            op_a_q      <= op_a;
            op_b_q      <= op_b;
            rd_q        <= bus.in_rd;
            rd_we_q     <= bus.in_rd_we;
            payload_q   <= bus.in_payload;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.out_op_a    = op_a_q;
    assign bus.out_op_b    = op_b_q;
    assign bus.out_rd      = rd_q;
    assign bus.out_rd_we   = rd_we_q;
    assign bus.out_payload = payload_q;
endmodule

// File: tb/tb_operand_fetch.sv
// Directed test of operand_fetch against a behavioural 32x32 register file.
module tb_operand_fetch;
    logic clock = 1'b0;
    logic ctrl_reset = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    logic [31:0] regs [32];

    operand_fetch_if #(.PAYLOAD_W(32)) bus ();

    operand_fetch #(.PAYLOAD_W(32), .CNT_W(2)) dut (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .bus        (bus)
    );

    always #5 clock = ~clock;

    assign bus.data_readRegA = regs[bus.ctrl_readRegA];
    assign bus.data_readRegB = regs[bus.ctrl_readRegB];

    always @(posedge clock) begin
        if (bus.ctrl_writeEnable) regs[bus.ctrl_writeReg] <= bus.data_writeReg;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [4:0] a, input logic [4:0] b,
                          input logic [4:0] d, input logic we, input logic [31:0] pl);
        bus.in_valid   = v;
        bus.in_rs_a    = a;
        bus.in_rs_b    = b;
        bus.in_rd      = d;
        bus.in_rd_we   = we;
        bus.in_payload = pl;
    endtask

    task automatic set_wb(input logic v, input logic [4:0] d, input logic [31:0] data);
        bus.wb_valid = v;
        bus.wb_rd    = d;
        bus.wb_data  = data;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'h11 * i;
        bus.out_ready = 1'b1;
        set_wb(1'b0, 5'd0, 32'd0);

        // reset held two cycles with a valid instruction presented
        ctrl_reset = 1'b0;
        set_in(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 32'hA0);
        tick();
        tick();
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("rst_op_a", bus.out_op_a, 32'd0);
        chk("rst_rd", {27'd0, bus.out_rd}, 32'd0);
        chk("rst_payload", bus.out_payload, 32'd0);
        ctrl_reset = 1'b1;
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0);
        tick();

        // independent issue
        set_in(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 32'hA1);
        #1;
        chk("ind_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("ind_raddr_a", {27'd0, bus.ctrl_readRegA}, 32'd1);
        tick();
        chk("ind_out_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("ind_op_a", bus.out_op_a, 32'h11);
        chk("ind_op_b", bus.out_op_b, 32'h22);
        chk("ind_rd", {27'd0, bus.out_rd}, 32'd3);
        chk("ind_rd_we", {31'd0, bus.out_rd_we}, 32'd1);
        chk("ind_payload", bus.out_payload, 32'hA1);

        // RAW on r3 until its writeback arrives, then bypass
        set_in(1'b1, 5'd3, 5'd0, 5'd4, 1'b0, 32'hA2);
        #1;
        chk("raw_stall0", {31'd0, bus.in_ready}, 32'd0);
        tick();
        chk("raw_drain_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("raw_stall1", {31'd0, bus.in_ready}, 32'd0);
        set_wb(1'b1, 5'd3, 32'hABCD);
        #1;
        chk("raw_bypass_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("raw_we", {31'd0, bus.ctrl_writeEnable}, 32'd1);
        chk("raw_wreg", {27'd0, bus.ctrl_writeReg}, 32'd3);
        chk("raw_wdata", bus.data_writeReg, 32'hABCD);
        tick();
        set_wb(1'b0, 5'd0, 32'd0);
        chk("raw_op_a", bus.out_op_a, 32'hABCD);
        chk("raw_op_b", bus.out_op_b, 32'd0);
        chk("raw_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("raw_payload", bus.out_payload, 32'hA2);
        set_in(1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 32'hA3);
        #1;
        chk("raw_cleared_ready", {31'd0, bus.in_ready}, 32'd1);
        tick();
        chk("raw_rf_a", bus.out_op_a, 32'hABCD);
        chk("raw_rf_b", bus.out_op_b, 32'hABCD);

        // saturation of r5 pending counter
        set_in(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 32'hB5);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("sat_issue_ready", {31'd0, bus.in_ready}, 32'd1);
            tick();
        end
        chk("sat_full_stall", {31'd0, bus.in_ready}, 32'd0);
        set_wb(1'b1, 5'd5, 32'h555);
        #1;
        chk("sat_wb_same_cycle", {31'd0, bus.in_ready}, 32'd0);
        tick();
        set_wb(1'b0, 5'd0, 32'd0);
        #1;
        chk("sat_after_wb", {31'd0, bus.in_ready}, 32'd1);
        tick();
        chk("sat_fourth_valid", {31'd0, bus.out_valid}, 32'd1);
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0);
        set_wb(1'b1, 5'd5, 32'h501);
        tick();
        set_wb(1'b1, 5'd5, 32'h502);
        tick();
        set_wb(1'b0, 5'd0, 32'd0);
        set_in(1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 32'hC5);
        #1;
        chk("sat_pend1_stall", {31'd0, bus.in_ready}, 32'd0);
        set_wb(1'b1, 5'd5, 32'h777);
        #1;
        chk("sat_pend1_bypass", {31'd0, bus.in_ready}, 32'd1);
        tick();
        set_wb(1'b0, 5'd0, 32'd0);
        chk("sat_bypass_op_a", bus.out_op_a, 32'h777);

        // backpressure holds the output stage
        bus.out_ready = 1'b0;
        set_in(1'b1, 5'd1, 5'd2, 5'd6, 1'b0, 32'hB1);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
            tick();
            chk("bp_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("bp_op_a", bus.out_op_a, 32'h777);
            chk("bp_payload", bus.out_payload, 32'hC5);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_ready", {31'd0, bus.in_ready}, 32'd1);
        tick();
        chk("bp_new_op_a", bus.out_op_a, 32'h11);
        chk("bp_new_payload", bus.out_payload, 32'hB1);
        chk("bp_new_rd", {27'd0, bus.out_rd}, 32'd6);

        // r0 source, destination and writeback
        set_in(1'b1, 5'd0, 5'd1, 5'd0, 1'b1, 32'hD0);
        set_wb(1'b1, 5'd0, 32'hDEAD);
        #1;
        chk("r0_write_en", {31'd0, bus.ctrl_writeEnable}, 32'd0);
        tick();
        set_wb(1'b0, 5'd0, 32'd0);
        chk("r0_op_a", bus.out_op_a, 32'd0);
        chk("r0_op_b", bus.out_op_b, 32'h11);
        chk("r0_regfile", regs[0], 32'd0);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("r0_never_full", {31'd0, bus.in_ready}, 32'd1);
            tick();
        end

        // writeback with nothing pending: regfile updated, no underflow
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0);
        set_wb(1'b1, 5'd7, 32'h7777);
        tick();
        set_wb(1'b0, 5'd0, 32'd0);
        set_in(1'b1, 5'd7, 5'd0, 5'd7, 1'b1, 32'hE7);
        #1;
        chk("uf_ready", {31'd0, bus.in_ready}, 32'd1);
        tick();
        chk("uf_op_a", bus.out_op_a, 32'h7777);
        set_in(1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 32'hE8);
        #1;
        chk("uf_pend_one", {31'd0, bus.in_ready}, 32'd0);

        // reset discards in-flight scoreboard state
        ctrl_reset = 1'b0;
        tick();
        chk("rst2_valid", {31'd0, bus.out_valid}, 32'd0);
        ctrl_reset = 1'b1;
        #1;
        chk("rst2_pend_cleared", {31'd0, bus.in_ready}, 32'd1);
        tick();
        chk("rst2_op_a", bus.out_op_a, 32'h7777);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
